// File: rtl/demux_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : demux_pkg
//  Description : Shared types and defaults for the 1-to-N serial demultiplexer
//                / deserializer (demux_1n_deser and its sub-blocks).
//                Contents:
//                  - demux_state_t   : collector state encoding
//                  - DEMUX_N_DEFAULT : default word width (output lanes)
//  Revision    : 1.0 - initial release
// ============================================================================
package demux_pkg;

    // Default number of output lanes; must be a power of two, at least 2.
    localparam int DEMUX_N_DEFAULT = 16;

    // PAR is only reachable when the parity option is compiled in.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        PAR   = 2'd2
    } demux_state_t;

endpackage : demux_pkg
`default_nettype wire

// File: rtl/demux_1n_deser_if.sv
`default_nettype none
// ============================================================================
//  Module      : demux_1n_deser_if
//  Description : Bundle of the serial input and parallel output signals of
//                demux_1n_deser.
//                  start      : frame-start pulse (arms / re-arms collector)
//                  din        : serial data bit
//                  din_valid  : din qualifier
//                  dout       : last completed N-bit word
//                  dout_valid : one-cycle pulse when dout updates
//                  sel_cnt    : lane index for the next accepted bit
//                  busy       : frame collection in progress
//                  par_err    : parity mismatch flag (DEMUX_PARITY_EN only)
//                Modports: master = serial source / consumer side,
//                          slave  = the deserializer itself.
//                Optional feature macro: DEMUX_PARITY_EN
//  Revision    : 1.0 - initial release
// ============================================================================
interface demux_1n_deser_if
    import demux_pkg::*;
#(
    parameter int N = DEMUX_N_DEFAULT
);

    logic                 start;
    logic                 din;
    logic                 din_valid;
    logic [N-1:0]         dout;
    logic                 dout_valid;
    logic [$clog2(N)-1:0] sel_cnt;
    logic                 busy;
`ifdef DEMUX_PARITY_EN
    logic                 par_err;
`endif

    modport master (
        output start,
        output din,
        output din_valid,
        input  dout,
        input  dout_valid,
        input  sel_cnt,
`ifdef DEMUX_PARITY_EN
        input  par_err,
`endif
        input  busy
    );

    modport slave (
        input  start,
        input  din,
        input  din_valid,
        output dout,
        output dout_valid,
        output sel_cnt,
`ifdef DEMUX_PARITY_EN
        output par_err,
`endif
        output busy
    );

endinterface : demux_1n_deser_if
`default_nettype wire

// File: rtl/demux_sel_cnt.sv
`default_nettype none
// ============================================================================
//  Module      : demux_sel_cnt
//  Description : Lane select counter for demux_1n_deser. Wraps naturally from
//                N-1 to 0 because N is a power of two.
//                  clk   : clock
//                  rst_n : synchronous active-low reset (count -> 0)
//                  clr   : synchronous clear (frame start / restart)
//                  inc   : advance by one (accepted data bit)
//                  cnt   : current lane index
//                  last  : cnt == N-1 (next accepted bit completes the word)
//  Revision    : 1.0 - initial release
// ============================================================================
module demux_sel_cnt
    import demux_pkg::*;
#(
    parameter int N = DEMUX_N_DEFAULT
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clr,
    input  logic                 inc,
    output logic [$clog2(N)-1:0] cnt,
    output logic                 last
);

    localparam int SW = $clog2(N);
    localparam logic [SW-1:0] c_last = SW'(N - 1);

    logic [SW-1:0] r_cnt;

    // Clear wins over increment: a restart drops the bit presented with it.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (clr) begin
            r_cnt <= '0;
        end else if (inc) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign cnt  = r_cnt;
    assign last = (r_cnt == c_last);

endmodule : demux_sel_cnt
`default_nettype wire

// File: rtl/demux_1n_deser.sv
`default_nettype none
// ============================================================================
//  Module      : demux_1n_deser
//  Description : Sequential 1-to-N demultiplexer / deserializer. Serial bits
//                are steered into lane sel_cnt of a shadow word; the finished
//                word is published on dout with a one-cycle dout_valid pulse.
//                Bit k on the line lands in dout[k].
//  Ports       : clk   - clock, rising edge
//                rst_n - synchronous active-low reset
//                bus   - demux_1n_deser_if.slave (start, din, din_valid,
//                        dout, dout_valid, sel_cnt, busy [, par_err])
//  Options     : DEMUX_PARITY_EN - when defined, each word is followed by an
//                even-parity bit, checked into par_err.
//  Revision    : 1.0 - initial release
// ============================================================================
module demux_1n_deser
    import demux_pkg::*;
#(
    parameter int N = DEMUX_N_DEFAULT
) (
    input  logic            clk,
    input  logic            rst_n,
    demux_1n_deser_if.slave bus
);

    localparam int SW = $clog2(N);

    demux_state_t  r_state;
    demux_state_t  w_state_nxt;

    logic [N-1:0]  r_shadow;
    logic [N-1:0]  w_shadow_upd;
    logic [N-1:0]  r_dout;
    logic          r_dout_valid;
`ifdef DEMUX_PARITY_EN
    logic          r_par_err;
`endif

    logic          w_cnt_clr;
    logic          w_cnt_inc;
    logic          w_shadow_clr;
    logic          w_shadow_wr;
    logic          w_word_done;
    logic [SW-1:0] w_sel_cnt;
    logic          w_sel_last;

    demux_sel_cnt #(
        .N (N)
    ) u_sel_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (w_cnt_clr),
        .inc   (w_cnt_inc),
        .cnt   (w_sel_cnt),
        .last  (w_sel_last)
    );

    // ------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM next state and datapath strobes
    // start is honoured in every state and always beats din_valid.
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_clr    = 1'b0;
        w_cnt_inc    = 1'b0;
        w_shadow_clr = 1'b0;
        w_shadow_wr  = 1'b0;
        w_word_done  = 1'b0;

        case (r_state)
            IDLE: begin
                if (bus.start) begin
                    w_state_nxt  = SHIFT;
                    w_cnt_clr    = 1'b1;
                    w_shadow_clr = 1'b1;
                end
            end

            SHIFT: begin
                if (bus.start) begin
                    w_state_nxt  = SHIFT;
                    w_cnt_clr    = 1'b1;
                    w_shadow_clr = 1'b1;
                end else if (bus.din_valid) begin
                    w_shadow_wr = 1'b1;
                    w_cnt_inc   = 1'b1;
                    if (w_sel_last) begin
`ifdef DEMUX_PARITY_EN
                        w_state_nxt = PAR;
`else
                        w_state_nxt = IDLE;
                        w_word_done = 1'b1;
`endif
                    end
                end
            end

`ifdef DEMUX_PARITY_EN
            PAR: begin
                if (bus.start) begin
                    w_state_nxt  = SHIFT;
                    w_cnt_clr    = 1'b1;
                    w_shadow_clr = 1'b1;
                end else if (bus.din_valid) begin
                    w_state_nxt = IDLE;
                    w_word_done = 1'b1;
                end
            end
`endif

            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Shadow word with the current bit merged in at the selected lane.
    always_comb begin
        w_shadow_upd            = r_shadow;
        w_shadow_upd[w_sel_cnt] = bus.din;
    end

    // ------------------------------------------------------------------
    // Shadow, output word and flags
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_shadow     <= '0;
            r_dout       <= '0;
            r_dout_valid <= 1'b0;
`ifdef DEMUX_PARITY_EN
            r_par_err    <= 1'b0;
`endif
        end else begin
            r_dout_valid <= w_word_done;

            if (w_shadow_clr) begin
                r_shadow <= '0;
            end else if (w_shadow_wr) begin
                r_shadow <= w_shadow_upd;
            end

            if (w_word_done) begin
`ifdef DEMUX_PARITY_EN
                // The shadow is already complete; din is the parity bit.
                r_dout    <= r_shadow;
                r_par_err <= bus.din ^ (^r_shadow);
`else
                // The final data bit is folded in on the same edge.
                r_dout    <= w_shadow_upd;
`endif
            end
        end
    end

    assign bus.dout       = r_dout;
    assign bus.dout_valid = r_dout_valid;
    assign bus.sel_cnt    = w_sel_cnt;
    assign bus.busy       = (r_state != IDLE);
`ifdef DEMUX_PARITY_EN
    assign bus.par_err    = r_par_err;
`endif

endmodule : demux_1n_deser
`default_nettype wire
